decode_3to8: RTL and testbench

Registered 3-to-8 line decoder with enable, used wherever a 3-bit binary select must drive eight one-hot strobes (chip selects, register-bank write enables, LED/demux lines). When enabled, exactly one output line asserts, the one whose index equals the input code. When disabled, no line asserts. Output is registered on the system clock, with a pass-through option, and clears on synchronous reset.

---
 rtl/decode_3to8.sv | 101 ++++++++++
 tb/tb_decode_3to8.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/decode_3to8.sv
// decode_3to8
//   Registered 3-to-8 line decoder with enable. When en is high, exactly one
//   output line asserts: the line whose index equals a. When en is low, no
//   line asserts.
//
// Parameters
//   ACTIVE_HIGH : 1 -> an asserted line is 1 and idle is 8'h00
//                 0 -> an asserted line is 0 and idle is 8'hFF
//   REGISTERED  : 1 -> out/vld/sel are flops, with one clock of latency
//                 0 -> out/vld/sel follow a/en directly; clk and reset_n are ignored
//
// Ports
//   clk     in   1  system clock, rising edge
//   reset_n in   1  synchronous active-low reset
//   a       in   3  select code
//   en      in   1  decoder enable
//   out     out  8  decoded lines, one-hot or idle
//   vld     out  1  out currently holds an asserted line
//   sel     out  3  code shown on out; holds its value while vld is low
module decode_3to8 #(
  parameter bit ACTIVE_HIGH = 1'b1,
  parameter bit REGISTERED  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] out,
  output logic       vld,
  output logic [2:0] sel
);

  localparam logic [7:0] IDLE = ACTIVE_HIGH ? 8'h00 : 8'hFF;

  logic [7:0] dec_ah;
  logic [7:0] dec;

  // The shift happens only under en. An X on a while en is low therefore
  // cannot reach the output.
  always_comb begin
    dec_ah = 8'h00;
    if (en) begin
      dec_ah = 8'h01 << a;
    end
  end

  assign dec = ACTIVE_HIGH ? dec_ah : ~dec_ah;

  generate
    if (REGISTERED) begin : g_reg
      logic [7:0] out_q;
      logic       vld_q;
      logic [2:0] sel_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          out_q <= IDLE;
          vld_q <= 1'b0;
          sel_q <= 3'b000;
        end else begin
          out_q <= dec;
          vld_q <= en;
          if (en) begin
            sel_q <= a;
          end
        end
      end

      assign out = out_q;
      assign vld = vld_q;
      assign sel = sel_q;
    end else begin : g_comb
      // clk and reset_n have no role in pass-through mode.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;

      assign out = dec;
      assign vld = en;
      assign sel = a;
    end
  endgenerate

`ifndef SYNTHESIS
  // The checks below work on an active-high view of out, so the same checks
  // apply to both polarities.
  logic [7:0] out_chk;
  assign out_chk = ACTIVE_HIGH ? out : ~out;

  always @(negedge clk) begin
    if (!$isunknown({out, vld, sel})) begin
      assert ($onehot0(out_chk))
        else $error("decode_3to8: out %h is neither one-hot nor idle", out);
      assert (vld || (out_chk == 8'h00))
        else $error("decode_3to8: vld low but out %h not idle", out);
      assert (!vld || out_chk[sel])
        else $error("decode_3to8: vld high but out[%0d] not asserted (out %h)", sel, out);
    end
  end
`endif

endmodule

// File: tb/tb_decode_3to8.sv
module tb_decode_3to8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] a;
  logic       en;

  logic [7:0] out_h, out_l, out_c;
  logic       vld_h, vld_l, vld_c;
  logic [2:0] sel_h, sel_l, sel_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_3to8 #(.ACTIVE_HIGH(1'b1), .REGISTERED(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .a(a), .en(en),
    .out(out_h), .vld(vld_h), .sel(sel_h));

  decode_3to8 #(.ACTIVE_HIGH(1'b0), .REGISTERED(1'b1)) u_pol (
    .clk(clk), .reset_n(reset_n), .a(a), .en(en),
    .out(out_l), .vld(vld_l), .sel(sel_l));

  decode_3to8 #(.ACTIVE_HIGH(1'b1), .REGISTERED(1'b0)) u_comb (
    .clk(clk), .reset_n(reset_n), .a(a), .en(en),
    .out(out_c), .vld(vld_c), .sel(sel_c));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Check both registered instances: the active-low one must be the exact
  // inverse of the active-high expectation and must share vld and sel.
  task automatic chk_reg(input string tag, input logic [7:0] e_out,
                         input logic e_vld, input logic [2:0] e_sel);
    check({tag, ".out"},   out_h, e_out);
    check({tag, ".out_n"}, out_l, ~e_out);
    check({tag, ".vld"},   {7'd0, vld_h}, {7'd0, e_vld});
    check({tag, ".vld_n"}, {7'd0, vld_l}, {7'd0, e_vld});
    check({tag, ".sel"},   {5'd0, sel_h}, {5'd0, e_sel});
    check({tag, ".sel_n"}, {5'd0, sel_l}, {5'd0, e_sel});
  endtask

  // Apply the inputs, then check the pass-through instance before the next edge.
  task automatic drive(input logic r, input logic [2:0] av, input logic ev,
                       input logic [7:0] e_out);
    reset_n = r;
    a       = av;
    en      = ev;
    #1;
    check("comb.out", out_c, e_out);
    check("comb.vld", {7'd0, vld_c}, {7'd0, ev});
    check("comb.sel", {5'd0, sel_c}, {5'd0, av});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a       = 3'b000;
    en      = 1'b0;
    #2;

    // Reset held for two edges while a decode of 5 is requested.
    drive(1'b0, 3'd5, 1'b1, 8'h20);
    step();
    chk_reg("rst1", 8'h00, 1'b0, 3'd0);
    step();
    chk_reg("rst2", 8'h00, 1'b0, 3'd0);
    drive(1'b1, 3'd5, 1'b1, 8'h20);
    step();
    chk_reg("rel", 8'h20, 1'b1, 3'd5);

    // Disabled sweep: idle output, sel holds 5.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0, 8'h00);
      step();
      chk_reg("dis", 8'h00, 1'b0, 3'd5);
    end

    // Full enabled sweep.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b1, 8'h01 << i);
      step();
      chk_reg("sweep", 8'h01 << i, 1'b1, 3'(i));
    end

    // X on a while en is low must not reach out.
    drive(1'b1, 3'bxxx, 1'b0, 8'h00);
    step();
    chk_reg("xa", 8'h00, 1'b0, 3'd7);

    // en toggling with a=3 held.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'd3, (k % 2 == 0), (k % 2 == 0) ? 8'h08 : 8'h00);
      step();
      chk_reg("tog", (k % 2 == 0) ? 8'h08 : 8'h00, (k % 2 == 0), 3'd3);
    end

    // Sweep with a one-cycle reset when a=6.
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        drive(1'b0, 3'(i), 1'b1, 8'h40);
        step();
        chk_reg("midrst", 8'h00, 1'b0, 3'd0);
      end else begin
        drive(1'b1, 3'(i), 1'b1, 8'h01 << i);
        step();
        chk_reg("sweep2", 8'h01 << i, 1'b1, 3'(i));
      end
    end

    // A reset_n pulse between edges must be ignored.
    drive(1'b1, 3'd4, 1'b1, 8'h10);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
    chk_reg("glitch", 8'h10, 1'b1, 3'd4);

    // Polarity: decode 2 gives FB on the active-low instance.
    drive(1'b1, 3'd2, 1'b1, 8'h04);
    step();
    check("pol.on", out_l, 8'hFB);
    chk_reg("pol", 8'h04, 1'b1, 3'd2);
    drive(1'b1, 3'd2, 1'b0, 8'h00);
    step();
    check("pol.off", out_l, 8'hFF);
    drive(1'b0, 3'd2, 1'b1, 8'h04);
    step();
    check("pol.rst", out_l, 8'hFF);
    chk_reg("pol.rst", 8'h00, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
